mem_bus_arbiter: RTL

- Shares the single MCU memory bus (address, write strobe, byte mode, write data, read data) between the CPU port and one DMA-style requester port (UART program loader, future DMA engine).
- CPU has priority. A starvation counter forces a DMA slot after a bounded wait.
- Tracks the owner of each access so one-cycle-latency read data returns to the correct requester.
- Sits between cpu/peripheral decode and the external memory interface.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the MCU memory bus between the CPU port and one
// DMA-style requester. CPU has priority; a starvation counter forces a DMA
// slot after MAX_WAIT-1 denied contested cycles. Read data (1-cycle latency)
// is steered back to the requester recorded in the owner pipeline.
// Optional feature macro: MEM_BUS_ARBITER_DMA_LOCK_EN adds i_dma_lock, which
// lets a granted DMA hold the bus across consecutive cycles.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_rd,
  input  logic              i_cpu_wr,
  input  logic              i_cpu_byt,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [15:0]       i_cpu_wdata,
  output logic              o_cpu_stall,
  output logic [15:0]       o_cpu_rdata,
  output logic              o_cpu_rvalid,
  input  logic              i_dma_req,
  input  logic              i_dma_wr,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [15:0]       i_dma_wdata,
`ifdef MEM_BUS_ARBITER_DMA_LOCK_EN
  input  logic              i_dma_lock,
`endif
  output logic              o_dma_gnt,
  output logic [15:0]       o_dma_rdata,
  output logic              o_dma_rvalid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr,
  output logic              o_mem_byt,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  owner_t           r_rd_owner;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_cpu_req;
  logic w_cpu_win;
  logic w_dma_win;
  logic w_lock_hold;

  assign w_cpu_req = i_cpu_rd | i_cpu_wr;

`ifdef MEM_BUS_ARBITER_DMA_LOCK_EN
  logic r_lock;

  assign w_lock_hold = r_lock & i_dma_lock & i_dma_req;

  // Lock is taken on a locked DMA grant and released when DMA drops lock or request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock <= 1'b0;
    end else if (!(i_dma_lock && i_dma_req)) begin
      r_lock <= 1'b0;
    end else if (w_dma_win) begin
      r_lock <= 1'b1;
    end
  end
`else
  assign w_lock_hold = 1'b0;
`endif

  // Per-cycle arbitration: lock, then CPU priority with forced DMA slot on starvation.
  always_comb begin
    w_cpu_win = 1'b0;
    w_dma_win = 1'b0;
    if (!rst) begin
      if (w_lock_hold) begin
        w_dma_win = 1'b1;
      end else if (w_cpu_req && i_dma_req) begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_dma_win = 1'b1;
        end else begin
          w_cpu_win = 1'b1;
        end
      end else if (w_cpu_req) begin
        w_cpu_win = 1'b1;
      end else if (i_dma_req) begin
        w_dma_win = 1'b1;
      end
    end
  end

  // Bus mux driven by the winner; idle bus is all zeros.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wr    = 1'b0;
    o_mem_byt   = 1'b0;
    o_mem_wdata = '0;
    if (w_cpu_win) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wr    = i_cpu_wr;
      o_mem_byt   = i_cpu_byt;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_dma_win) begin
      o_mem_addr  = i_dma_addr;
      o_mem_wr    = i_dma_wr;
      o_mem_wdata = i_dma_wdata;
    end
  end

  assign o_dma_gnt    = w_dma_win;
  assign o_cpu_stall  = ~rst & w_cpu_req & ~w_cpu_win;
  assign o_cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign o_dma_rvalid = (r_rd_owner == OWN_DMA);
  assign o_cpu_rdata  = rst ? 16'h0000 : i_mem_rdata;
  assign o_dma_rdata  = rst ? 16'h0000 : i_mem_rdata;

  // Owner pipeline and starvation counter; a CPU rd+wr counts as a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_owner <= OWN_NONE;
      r_wait_cnt <= '0;
    end else begin
      if (w_cpu_win && !i_cpu_wr) begin
        r_rd_owner <= OWN_CPU;
      end else if (w_dma_win && !i_dma_wr) begin
        r_rd_owner <= OWN_DMA;
      end else begin
        r_rd_owner <= OWN_NONE;
      end

      if (!i_dma_req || w_dma_win || w_lock_hold) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_LAST) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule
